// File: rtl/imm_packer.sv
// imm_packer: packs decoded RV32I fields and a 32-bit immediate into an instruction word (2-stage valid/ready).
// Optional IMM_PACKER_ERR_NOP_EN replaces erroneous words with NOP.
module imm_packer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [31:0]         in_imm,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [2:0]          in_funct3,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [6:0]          in_funct7,
  input  logic [11:0]         in_csr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [ERRCNT_W-1:0] err_cnt
);
  logic s1_valid, s1_err, in_err, s2_load, out_hs;
  logic [2:0] s1_fmt, s1_f3;
  logic [31:0] s1_imm, packed_w, word;
  logic [6:0] s1_op, s1_f7;
  logic [4:0] s1_rd, s1_rs1, s1_rs2;
  logic [11:0] s1_csr;
  logic sx11, sx12, sx20;
  assign sx11 = &in_imm[31:11] | ~|in_imm[31:11];
  assign sx12 = &in_imm[31:12] | ~|in_imm[31:12];
  assign sx20 = &in_imm[31:20] | ~|in_imm[31:20];
  assign out_hs   = out_valid && out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  always_comb begin
    case (in_fmt)
      3'd0, 3'd2: in_err = !sx11;
      3'd1, 3'd6: in_err = |in_imm[31:5];
      3'd3:       in_err = in_imm[0] | !sx12;
      3'd4:       in_err = |in_imm[11:0];
      3'd5:       in_err = in_imm[0] | !sx20;
      default:    in_err = 1'b1;
    endcase
  end
  always_comb begin
    case (s1_fmt)
      3'd0:    packed_w = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      3'd1:    packed_w = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
      3'd2:    packed_w = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
      3'd3:    packed_w = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11], s1_op};
      3'd4:    packed_w = {s1_imm[31:12], s1_rd, s1_op};
      3'd5:    packed_w = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
      3'd6:    packed_w = {s1_csr, s1_imm[4:0], s1_f3, s1_rd, s1_op};
      default: packed_w = '0;
    endcase
  end
`ifdef IMM_PACKER_ERR_NOP_EN
  assign word = s1_err ? 32'h0000_0013 : packed_w;
`else
  assign word = packed_w;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || clr) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_fmt    <= '0;
      s1_imm    <= '0;
      s1_op     <= '0;
      s1_rd     <= '0;
      s1_f3     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_f7     <= '0;
      s1_csr    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      err_cnt   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_err <= in_err;
        s1_fmt <= in_fmt;
        s1_imm <= in_imm;
        s1_op  <= in_opcode;
        s1_rd  <= in_rd;
        s1_f3  <= in_funct3;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f7  <= in_funct7;
        s1_csr <= in_csr;
      end
      if (s2_load) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_err   <= s1_err;
      end else if (out_hs) out_valid <= 1'b0;
      if (out_hs) begin
        out_addr <= out_addr + ADDR_W'(4);
        if (out_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imm_packer.sv
// tb_imm_packer: directed scoreboard bench for imm_packer.
module tb_imm_packer;
  logic clk = 0, rstn = 0, clr = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
  logic [2:0] in_fmt = 0, in_funct3 = 0;
  logic [31:0] in_imm = 0, out_instr, out_addr;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [11:0] in_csr = 0;
  logic [7:0] err_cnt;
  logic [32:0] q[$];
  logic [32:0] pend;
  logic [31:0] exp_addr = 0;
  logic [7:0] exp_cnt = 0;
  logic acc;
  int nvec = 0, nmis = 0, k;
  always #5 clk = ~clk;
  imm_packer dut (.clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_csr(in_csr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .out_addr(out_addr), .err_cnt(err_cnt));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  // Reference built from signed ranges rather than bit-equality tests.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] i, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [11:0] csr);
    int s;
    logic e;
    logic [31:0] w;
    s = i;
    case (f)
      3'd0: begin e = s < -2048 || s > 2047; w = {i[11:0], rs1, f3, rd, op}; end
      3'd1: begin e = i > 31; w = {f7, i[4:0], rs1, f3, rd, op}; end
      3'd2: begin e = s < -2048 || s > 2047; w = {i[11:5], rs2, rs1, f3, i[4:0], op}; end
      3'd3: begin e = i[0] || s < -4096 || s > 4095; w = {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], op}; end
      3'd4: begin e = i[11:0] != 0; w = {i[31:12], rd, op}; end
      3'd5: begin e = i[0] || s < -(1 << 20) || s > (1 << 20) - 1; w = {i[20], i[10:1], i[11], i[19:12], rd, op}; end
      3'd6: begin e = i > 31; w = {csr, i[4:0], f3, rd, op}; end
      default: begin e = 1'b1; w = 32'h0; end
    endcase
`ifdef IMM_PACKER_ERR_NOP_EN
    if (e) w = 32'h0000_0013;
`endif
    return {e, w};
  endfunction
  task automatic tick();
    logic ih, oh, oe;
    logic [32:0] e;
    #1;
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    oe = 1'b0;
    if (!clr && oh) begin
      chk("out_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        oe = e[32];
        chk("instr", out_instr, e[31:0]);
        chk("err", 32'(out_err), 32'(e[32]));
        chk("addr", out_addr, exp_addr);
        chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      end
    end
    if (!clr && ih) q.push_back(pend);
    acc = ih;
    @(posedge clk);
    if (clr) begin
      q.delete();
      exp_addr = 0;
      exp_cnt = 0;
    end else if (oh) begin
      exp_addr += 4;
      if (oe && exp_cnt != 8'hFF) exp_cnt++;
    end
    @(negedge clk);
  endtask
  task automatic setw(input logic [2:0] f, input logic [31:0] i, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
      input logic [11:0] csr, input logic [32:0] e);
    in_valid = 1; in_fmt = f; in_imm = i; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_csr = csr; pend = e;
  endtask
  task automatic wait_acc();
    int n = 0;
    acc = 0;
    while (!acc && n < 20) begin tick(); n++; end
    chk("accept", 32'(acc), 1);
    in_valid = 0;
  endtask
  task automatic put(input logic [2:0] f, input logic [31:0] i, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
      input logic [11:0] csr, input logic [32:0] e);
    setw(f, i, op, rd, f3, rs1, rs2, f7, csr, e);
    wait_acc();
  endtask
  task automatic putm(input logic [2:0] f, input logic [31:0] i, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
      input logic [11:0] csr);
    put(f, i, op, rd, f3, rs1, rs2, f7, csr, model(f, i, op, rd, f3, rs1, rs2, f7, csr));
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (q.size() > 0 && n < 100) begin tick(); n++; end
    chk("drain", 32'(q.size()), 0);
  endtask
  initial begin
    logic [32:0] bad_b;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    rstn = 1;
    out_ready = 1;
    put(0, 32'hFFFF_FFFF, 7'h13, 1, 0, 0, 0, 0, 0, {1'b0, 32'hFFF0_0093});
    chk("lat1", 32'(out_valid), 0);
    tick();
    chk("lat2", 32'(out_valid), 1);
    drain();
    put(3, 32'hFFFF_FFFC, 7'h63, 0, 0, 0, 0, 0, 0, {1'b0, 32'hFE00_0EE3});
    put(4, 32'h1234_5000, 7'h37, 5, 0, 0, 0, 0, 0, {1'b0, 32'h1234_52B7});
`ifdef IMM_PACKER_ERR_NOP_EN
    bad_b = {1'b1, 32'h0000_0013};
`else
    bad_b = {1'b1, 32'h0000_0163};
`endif
    put(3, 32'h3, 7'h63, 0, 0, 0, 0, 0, 0, bad_b);
    drain();
    chk("cnt_one", 32'(err_cnt), 1);
    putm(1, 32'd7, 7'h13, 2, 1, 3, 0, 7'h20, 0);
    putm(2, 32'hFFFF_FFFC, 7'h23, 0, 2, 4, 3, 0, 0);
    putm(5, 32'h0000_0800, 7'h6F, 1, 0, 0, 0, 0, 0);
    putm(5, 32'hFFFF_FFFE, 7'h6F, 1, 0, 0, 0, 0, 0);
    putm(5, 32'h000F_FFFE, 7'h6F, 3, 0, 0, 0, 0, 0);
    putm(6, 32'd5, 7'h73, 6, 5, 0, 0, 0, 12'h305);
    putm(0, 32'd2047, 7'h13, 1, 0, 2, 0, 0, 0);
    putm(0, 32'd2048, 7'h13, 1, 0, 2, 0, 0, 0);
    putm(2, 32'hFFFF_F7FF, 7'h23, 0, 2, 1, 2, 0, 0);
    putm(3, 32'd4096, 7'h63, 0, 1, 1, 2, 0, 0);
    putm(5, 32'h0010_0000, 7'h6F, 1, 0, 0, 0, 0, 0);
    putm(5, 32'd3, 7'h6F, 1, 0, 0, 0, 0, 0);
    putm(4, 32'h1234_5001, 7'h37, 5, 0, 0, 0, 0, 0);
    putm(1, 32'd32, 7'h13, 2, 5, 3, 0, 0, 0);
    putm(6, 32'h40, 7'h73, 6, 5, 0, 0, 0, 12'h300);
    drain();
    clr = 1;
    tick();
    clr = 0;
    chk("clr_addr", out_addr, 0);
    out_ready = 0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 3) setw(4, (k + 1) << 12, 7'h37, 5'(k + 1), 0, 0, 0, 0, 0,
                      model(4, (k + 1) << 12, 7'h37, 5'(k + 1), 0, 0, 0, 0, 0));
      else in_valid = 0;
      tick();
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1;
    wait_acc();
    drain();
    chk("bp_next_addr", out_addr, 12);
    for (int i = 0; i < 300; i++) putm(7, i, 7'h13, 1, 0, 0, 0, 0, 0);
    drain();
    chk("cnt_sat", 32'(err_cnt), 255);
    putm(0, 32'd1, 7'h13, 1, 0, 0, 0, 0, 0);
    putm(0, 32'd2, 7'h13, 1, 0, 0, 0, 0, 0);
    chk("clr_pre_valid", 32'(out_valid), 1);
    setw(0, 32'd3, 7'h13, 1, 0, 0, 0, 0, 0, model(0, 32'd3, 7'h13, 1, 0, 0, 0, 0, 0));
    clr = 1;
    tick();
    clr = 0;
    in_valid = 0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_addr2", out_addr, 0);
    chk("clr_cnt", 32'(err_cnt), 0);
    tick();
    chk("clr_flushed", 32'(out_valid), 0);
    putm(7, 0, 0, 0, 0, 0, 0, 0, 0);
    putm(7, 1, 0, 0, 0, 0, 0, 0, 0);
    putm(7, 2, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pre_cnt", 32'(err_cnt), 1);
    chk("rst_pre_valid", 32'(out_valid), 1);
    rstn = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_addr", out_addr, 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    q.delete();
    exp_addr = 0;
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1;
    tick();
    chk("arst_flushed", 32'(out_valid), 0);
    putm(4, 32'hABCD_E000, 7'h17, 9, 0, 0, 0, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
